// File: rtl/cali_err_gen.sv
// Upstream conditioning for the DCD-RLS/LMS calibrator: fractional phase accumulator,
// TDC-latency alignment, DC-removed and clipped error, and lock/settle/freeze enable FSM.
module cali_err_gen #(
    parameter int unsigned TDC_LAT    = 2,
    parameter int unsigned SETTLE_CYC = 256,
    parameter int unsigned AVG_SHIFT  = 6,
    parameter real         ERR_GAIN   = 1.0,
    parameter real         ERR_CLIP   = 0.5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOCK_IN,
    input  logic        FREEZE,
    input  real         FCW_FRAC,
    input  real         TDC_ERR,
    output real         X_DTC,
    output logic        CARRY,
    output real         X_CALI,
    output real         ERR,
    output logic        EN,
    output logic [1:0]  STATE,
    output logic [15:0] SAT_CNT
);

    localparam real FCW_MAX = 1.0 - 2.0 ** (-40.0);
    localparam real AVG_K   = 1.0 / (2.0 ** AVG_SHIFT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CALI   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sat_q, sat_d;
    real         acc_q, acc_d;
    logic        carry_q, carry_d;
    real         dc_q, dc_d;
    real         xcal_q, xcal_d;
    real         err_q, err_d;
    logic        en_q, en_d;

    real         fcw, acc_sum;
    real         e_hp, e_g, e_c;
    logic        clip, cali_ok;
    real         x_al;
    logic        v_al;

    // Aligned copy of X_DTC; the valid bit marks samples that entered after reset.
    if (TDC_LAT == 0) begin : g_nodly
        assign x_al = acc_q;
        assign v_al = 1'b1;
    end else begin : g_dly
        real                dly_q [TDC_LAT];
        logic [TDC_LAT-1:0] vld_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                for (int unsigned i = 0; i < TDC_LAT; i++) begin
                    dly_q[i] <= 0.0;
                end
                vld_q <= '0;
            end else begin
                dly_q[0] <= acc_q;
                vld_q[0] <= 1'b1;
                for (int unsigned i = 1; i < TDC_LAT; i++) begin
                    dly_q[i] <= dly_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign x_al = dly_q[TDC_LAT-1];
        assign v_al = vld_q[TDC_LAT-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= '0;
            acc_q   <= 0.0;
            carry_q <= 1'b0;
            dc_q    <= 0.0;
            xcal_q  <= 0.0;
            err_q   <= 0.0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            dc_q    <= dc_d;
            xcal_q  <= xcal_d;
            err_q   <= err_d;
            en_q    <= en_d;
        end
    end

    // Loss of lock overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!LOCK_IN) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
                SETTLE: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == 16'(SETTLE_CYC - 1)) begin
                        state_d = FREEZE ? HOLD : CALI;
                    end
                end
                CALI: begin
                    if (FREEZE) state_d = HOLD;
                end
                HOLD: begin
                    if (!FREEZE) state_d = CALI;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fcw = FCW_FRAC;
        if (fcw < 0.0) begin
            fcw = 0.0;
        end else if (fcw > FCW_MAX) begin
            fcw = FCW_MAX;
        end
        acc_sum = acc_q + fcw;
        if (acc_sum >= 1.0) begin
            acc_d   = acc_sum - 1.0;
            carry_d = 1'b1;
        end else begin
            acc_d   = acc_sum;
            carry_d = 1'b0;
        end

        e_hp = TDC_ERR - dc_q;
        e_g  = ERR_GAIN * e_hp;
        clip = (e_g > ERR_CLIP) || (e_g < -ERR_CLIP);
        e_c  = e_g;
        if (e_g > ERR_CLIP) begin
            e_c = ERR_CLIP;
        end else if (e_g < -ERR_CLIP) begin
            e_c = -ERR_CLIP;
        end

        cali_ok = (state_q == CALI) && v_al;
        xcal_d  = x_al;
        err_d   = cali_ok ? e_c : 0.0;
        en_d    = cali_ok;

        dc_d  = dc_q;
        sat_d = sat_q;
        if ((state_q == SETTLE) || (state_q == CALI)) begin
            dc_d = dc_q + (TDC_ERR - dc_q) * AVG_K;
        end
        if (cali_ok && clip && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
        end
        // Clearing on the way into IDLE takes precedence over the update above.
        if (state_d == IDLE) begin
            dc_d  = 0.0;
            sat_d = '0;
        end
    end

    assign X_DTC   = acc_q;
    assign CARRY   = carry_q;
    assign X_CALI  = xcal_q;
    assign ERR     = err_q;
    assign EN      = en_q;
    assign STATE   = state_q;
    assign SAT_CNT = sat_q;

endmodule

// File: tb/tb_cali_err_gen.sv
// Directed bench for cali_err_gen: accumulator, alignment, FSM timing, DC removal, clipping.
module tb_cali_err_gen;

    logic        CLK;
    logic        RST;
    logic        LOCK_IN;
    logic        FREEZE;
    real         FCW_FRAC;
    real         TDC_ERR;
    real         X_DTC;
    logic        CARRY;
    real         X_CALI;
    real         ERR;
    logic        EN;
    logic [1:0]  STATE;
    logic [15:0] SAT_CNT;

    int n_checks = 0;
    int n_errors = 0;

    real xs [8] = '{0.25, 0.5, 0.75, 0.0, 0.25, 0.5, 0.75, 0.0};
    int  cs [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    real hist [0:15];

    cali_err_gen #(
        .TDC_LAT    (2),
        .SETTLE_CYC (256),
        .AVG_SHIFT  (6),
        .ERR_GAIN   (1.0),
        .ERR_CLIP   (0.5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LOCK_IN  (LOCK_IN),
        .FREEZE   (FREEZE),
        .FCW_FRAC (FCW_FRAC),
        .TDC_ERR  (TDC_ERR),
        .X_DTC    (X_DTC),
        .CARRY    (CARRY),
        .X_CALI   (X_CALI),
        .ERR      (ERR),
        .EN       (EN),
        .STATE    (STATE),
        .SAT_CNT  (SAT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input real obs, input real exp);
        n_checks++;
        if ((obs - exp > 1.0e-6) || (exp - obs > 1.0e-6)) begin
            n_errors++;
            $display("FAIL %s: got %0.9f expected %0.9f", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  en_hi;
        int  neg;
        int  en_lo;
        real m;
        real x1;

        RST = 1'b1; LOCK_IN = 1'b0; FREEZE = 1'b0; FCW_FRAC = 0.25; TDC_ERR = 0.0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_xdtc",  X_DTC,   0.0);
        chk("rst_carry", CARRY,   0.0);
        chk("rst_state", STATE,   0.0);
        chk("rst_en",    EN,      0.0);
        chk("rst_err",   ERR,     0.0);
        chk("rst_xcali", X_CALI,  0.0);
        chk("rst_sat",   SAT_CNT, 0.0);
        RST = 1'b0;

        for (int k = 0; k < 8; k++) begin
            tick();
            chk("acc_xdtc",  X_DTC, xs[k]);
            chk("acc_carry", CARRY, real'(cs[k]));
        end
        chk("idle_state", STATE, 0.0);
        chk("idle_en",    EN,    0.0);
        chk("idle_err",   ERR,   0.0);

        // Alignment with FCW=0.1; lock asserted after cycle 10
        RST = 1'b1; #2; RST = 1'b0;
        FCW_FRAC = 0.1; TDC_ERR = 0.2;
        m = 0.0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            m = m + 0.1;
            if (m >= 1.0) m = m - 1.0;
            hist[k] = m;
            chk("align_xdtc",  X_DTC,  m);
            chk("align_xcali", X_CALI, (k > 3) ? hist[k-3] : 0.0);
        end
        LOCK_IN = 1'b1;

        n = 0; en_hi = 0;
        tick();
        while (STATE == 2'd1 && n < 300) begin
            n++;
            if (EN) en_hi++;
            tick();
        end
        chk("settle_len",   n,     256.0);
        chk("settle_en",    en_hi, 0.0);
        chk("cali_state",   STATE, 2.0);
        chk("cali_entry_en", EN,   0.0);
        tick();
        chk("en_rise",   EN,  1.0);
        chk("first_err", ERR, 0.2 * ((63.0 / 64.0) ** 256));

        neg = 0; en_lo = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (ERR < 0.0) neg++;
            if (!EN) en_lo++;
        end
        chk("err_nonneg",    neg,   0.0);
        chk("en_held",       en_lo, 0.0);
        chk("err_converged", ERR,   0.0);

        // Freeze for 20 edges; a moving TDC_ERR must not leak into dc
        FREEZE = 1'b1;
        tick();
        chk("hold_state", STATE, 3.0);
        TDC_ERR = 0.3;
        tick();
        chk("hold_en",  EN,  0.0);
        chk("hold_err", ERR, 0.0);
        repeat (18) tick();
        FREEZE = 1'b0; TDC_ERR = 0.25;
        tick();
        chk("unfreeze_state", STATE, 2.0);
        chk("unfreeze_en",    EN,    0.0);
        tick();
        chk("refire_en", EN,  1.0);
        chk("dc_held",   ERR, 0.05);

        TDC_ERR = 5.0;
        tick();
        chk("clip_pos", ERR,     0.5);
        chk("sat_1",    SAT_CNT, 1.0);
        repeat (3) tick();
        chk("sat_4",      SAT_CNT, 4.0);
        chk("clip_pos_4", ERR,     0.5);
        TDC_ERR = -5.0;
        tick();
        chk("clip_neg", ERR,     -0.5);
        chk("sat_5",    SAT_CNT, 5.0);

        LOCK_IN = 1'b0; TDC_ERR = 0.0;
        tick();
        chk("unlock_state", STATE,   0.0);
        chk("unlock_sat",   SAT_CNT, 0.0);
        tick();
        chk("unlock_en",  EN,  0.0);
        chk("unlock_err", ERR, 0.0);

        // Relock with zero error: any dc surviving IDLE would show as nonzero ERR
        LOCK_IN = 1'b1;
        n = 0;
        tick();
        while (STATE != 2'd2 && n < 300) begin
            n++;
            tick();
        end
        chk("relock_len", n, 256.0);
        tick();
        chk("relock_en",  EN,  1.0);
        chk("dc_cleared", ERR, 0.0);

        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("async_state", STATE, 0.0);
        chk("async_en",    EN,    0.0);
        chk("async_xdtc",  X_DTC, 0.0);
        LOCK_IN = 1'b0;
        #2;
        RST = 1'b0;

        // FCW clamping at both ends of the range
        FCW_FRAC = 1.5;
        tick();
        x1 = 1.0 - 2.0 ** (-40.0);
        chk("clamp_hi_x",     X_DTC, x1);
        chk("clamp_hi_carry", CARRY, 0.0);
        tick();
        chk("clamp_hi_wrap", CARRY, 1.0);
        x1 = 1.0 - 2.0 ** (-39.0);
        FCW_FRAC = -0.5;
        tick();
        chk("clamp_lo_carry", CARRY, 0.0);
        chk("clamp_lo_x",     X_DTC, x1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cali_err_gen.md
Name: cali_err_gen

Overview:
- Upstream conditioning stage for the piecewise DCD-RLS/LMS calibrator.
- Generates the fractional phase X that drives the DTC path and the calibrator, time-aligns X with the TDC phase error, and removes DC from that error with clipping.
- Produces the calibrator EN through a lock/settle/freeze state machine.
- Behavioural real-valued model, same flavour as the calibrator; single clock domain.

Parameters:
- TDC_LAT, 2, cycles from an X_DTC value to its TDC_ERR sample (legal range 0..7).
- SETTLE_CYC, 256, cycles spent in SETTLE before calibration starts (legal range 1..65535).
- AVG_SHIFT, 6, DC averager time constant: coefficient 2^-AVG_SHIFT.
- ERR_GAIN, 1.0, real gain applied after DC removal.
- ERR_CLIP, 0.5, real symmetric clip magnitude of ERR.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous active-high reset.
- LOCK_IN  input  1  PLL lock indication, synchronous to CLK.
- FREEZE  input  1  pauses calibration, holding calibrator state.
- FCW_FRAC  input  real  fractional frequency control word, valid range [0,1).
- TDC_ERR  input  real  raw TDC phase error sample.
- X_DTC  output  real  current fractional phase, 0 <= X_DTC < 1.
- CARRY  output  1  accumulator wrap flag for the divider.
- X_CALI  output  real  X aligned with ERR; drives the calibrator X.
- ERR  output  real  conditioned error; drives the calibrator ERR.
- EN  output  1  calibrator enable.
- STATE  output  2  0 IDLE, 1 SETTLE, 2 CALI, 3 HOLD.
- SAT_CNT  output  16  count of clipped samples.

Behaviour:
- Reset (RST=1, async): acc=0, X_DTC=0, CARRY=0, delay line all 0, valid bits 0, dc=0, X_CALI=0, ERR=0, EN=0, STATE=IDLE, settle counter=0, SAT_CNT=0.
- FCW handling: FCW_FRAC is clamped to [0, 1-2^-40] before use.
- Accumulator, each cycle: s = acc + FCW_FRAC.
  - If s>=1: acc<=s-1 and CARRY<=1.
  - Else: acc<=s and CARRY<=0.
  - X_DTC = acc (registered).
- Delay line: depth TDC_LAT, shifts every cycle regardless of state. x_al = X_DTC delayed TDC_LAT cycles; with TDC_LAT=0, x_al = X_DTC directly.
- Valid bit: travels with the delay line. A delayed sample is valid only if it entered after reset.
- Error path, per cycle:
  - e_hp = TDC_ERR - dc.
  - e_g = ERR_GAIN*e_hp.
  - e_c = min(max(e_g, -ERR_CLIP), ERR_CLIP).
  - clip = (|e_g| > ERR_CLIP).
- DC averager: dc <= dc + (TDC_ERR - dc)*2^-AVG_SHIFT, in SETTLE and CALI only. dc is frozen in HOLD and cleared to 0 on entry to IDLE.
- Output register, one cycle after the TDC_ERR sample:
  - X_CALI <= x_al.
  - ERR <= (state==CALI && valid) ? e_c : 0.
  - EN <= (state==CALI && valid).
  - Total X_DTC->X_CALI latency is TDC_LAT+1; X_CALI, ERR and EN always change on the same edge.
- FSM (STATE reflects current registered state); LOCK_IN=0 has priority over everything:
  - IDLE: LOCK_IN=1 -> SETTLE, counter cleared to 0.
  - SETTLE: counter increments each cycle. LOCK_IN=0 -> IDLE. When counter==SETTLE_CYC-1, next state is CALI (FREEZE=1 at that moment -> HOLD instead).
  - CALI: LOCK_IN=0 -> IDLE; FREEZE=1 -> HOLD.
  - HOLD: LOCK_IN=0 -> IDLE; FREEZE=0 -> CALI. EN=0 and ERR=0 while in HOLD.
- SAT_CNT: increments when state==CALI && valid && clip, saturating at 65535. Cleared on entry to IDLE.
- Reset mid-operation: all state returns to reset values immediately. The accumulator phase is lost and restarts from 0.
- The accumulator and delay line are not gated by FSM state, so X_DTC is continuous through HOLD/IDLE transitions.

Test Plan:
- FCW_FRAC=0.25, RST released, LOCK_IN=0 -> X_DTC sequence 0.25, 0.5, 0.75, 0.0 (CARRY=1 on the 0.0 cycle), repeating. STATE stays 0, EN=0, ERR=0.
- TDC_LAT=2, FCW_FRAC=0.1 -> X_CALI equals X_DTC delayed exactly 3 cycles. The first 3 X_CALI values after reset are 0.
- LOCK_IN=1 at cycle 10, SETTLE_CYC=256, FREEZE=0 -> STATE=1 for 256 cycles, then 2. EN rises on the edge after CALI entry and not before.
- Constant TDC_ERR=0.2, AVG_SHIFT=6 -> dc converges toward 0.2 and ERR decays toward 0. After 1000 CALI cycles |ERR|<1e-6; ERR is never negative.
- In CALI, apply TDC_ERR step to 5.0 with ERR_CLIP=0.5 -> ERR=+0.5 on the next edge. SAT_CNT increments every cycle while ERR is clipped.
- In CALI, FREEZE=1 for 20 cycles -> STATE=3, EN=0, ERR=0, dc unchanged. Release FREEZE -> STATE=2, EN=1 the following edge. Then LOCK_IN=0 -> STATE=0, SAT_CNT=0, dc=0.
